// File: rtl/dma_dsc_cache_pkg.sv
// rtl/dma_dsc_cache_pkg.sv - SECDED helpers and injection encodings for the descriptor cache
package dma_dsc_cache_pkg;

  localparam int MAX_W = 256;
  localparam int MAX_P = 9;

  localparam logic [1:0] INJ_NONE  = 2'b00;
  localparam logic [1:0] INJ_BIT0  = 2'b01;
  localparam logic [1:0] INJ_BIT01 = 2'b10;

  // Smallest r with 2^r >= width + r + 1; the overall parity bit is stored separately.
  function automatic int hamming_bits(input int width);
    int r;
    r = 1;
    while ((1 << r) < width + r + 1) r++;
    return r;
  endfunction

  // Codeword position of data bit idx; power-of-two positions belong to check bits.
  function automatic int data_pos(input int idx);
    int p;
    p = idx + 1;
    for (int i = 0; i <= MAX_P; i++) begin
      if ((1 << i) <= p) p++;
    end
    return p;
  endfunction

  function automatic logic [MAX_P-1:0] hamming_check(input logic [MAX_W-1:0] data,
                                                     input int width);
    logic [MAX_P-1:0] chk;
    int p;
    chk = '0;
    for (int j = 0; j < MAX_W; j++) begin
      p = data_pos(j);
      if (j < width && data[j]) chk = chk ^ p[MAX_P-1:0];
    end
    return chk;
  endfunction

  function automatic logic [MAX_W-1:0] inj_mask(input logic [1:0] inj);
    logic [MAX_W-1:0] m;
    m = '0;
    case (inj)
      INJ_BIT0:  m[0] = 1'b1;
      INJ_BIT01: m[1:0] = 2'b11;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dma_secded_dec.sv
// rtl/dma_secded_dec.sv - combinational SECDED syndrome, correction and error flags
module dma_secded_dec
  import dma_dsc_cache_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int P     = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [P-1:0]     chk,
  input  logic             par,
  output logic [WIDTH-1:0] corr_data,
  output logic             sb_err,
  output logic             db_err
);

  logic [MAX_W-1:0] ext;
  logic [P-1:0]     syn;
  logic             perr;
  int               p;

  always_comb begin
    ext       = MAX_W'(data);
    syn       = P'(hamming_check(ext, WIDTH)) ^ chk;
    perr      = ^data ^ ^chk ^ par;
    corr_data = data;
    sb_err    = 1'b0;
    db_err    = 1'b0;
    p         = 0;
    if (perr) begin
      // Syndrome naming a check bit or zero (parity bit) leaves the data untouched.
      sb_err = 1'b1;
      for (int j = 0; j < WIDTH; j++) begin
        p = data_pos(j);
        if (p == int'(syn)) corr_data[j] = ~data[j];
      end
    end else if (syn != '0) begin
      db_err = 1'b1;
    end
  end

endmodule

// File: rtl/dma_dsc_cache_ecc.sv
// rtl/dma_dsc_cache_ecc.sv - descriptor cache RAM with SECDED, 2-cycle read pipe and error capture
module dma_dsc_cache_ecc
  import dma_dsc_cache_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ECC_EN     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  WEN,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [WIDTH-1:0]      WDATA,
  input  logic [1:0]            ERR_INJ,
  input  logic                  REN,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [WIDTH-1:0]      RDATA,
  output logic                  RVALID,
  output logic                  SB_CORRECT,
  output logic                  DB_DETECT,
  input  logic                  CLR_ERR,
  output logic [CNT_WIDTH-1:0]  SB_COUNT,
  output logic [CNT_WIDTH-1:0]  DB_COUNT,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic                  ERR_VALID
);

  localparam int P      = hamming_bits(WIDTH);
  localparam int CHK_W  = (ECC_EN != 0) ? P + 1 : 0;
  localparam int WORD_W = WIDTH + CHK_W;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]      wdata_st;
  logic [WORD_W-1:0]     wword;
  logic [WORD_W-1:0]     s1_word;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_valid;
  logic [WIDTH-1:0]      dec_data;
  logic                  dec_sb;
  logic                  dec_db;
  logic                  sb_ev;
  logic                  db_ev;

  // Check bits cover the clean data; injection only corrupts what lands in the array.
  assign wdata_st = WDATA ^ WIDTH'(inj_mask(ERR_INJ));

  if (ECC_EN != 0) begin : g_enc
    logic [P-1:0] wchk;
    assign wchk  = P'(hamming_check(MAX_W'(WDATA), WIDTH));
    assign wword = {^WDATA ^ ^wchk, wchk, wdata_st};
  end else begin : g_noenc
    assign wword = wdata_st;
  end

  always_ff @(posedge CLOCK) begin
    if (WEN) mem[WADDR] <= wword;
    if (REN) begin
      s1_word <= (WEN && (WADDR == RADDR)) ? wword : mem[RADDR];
      s1_addr <= RADDR;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) s1_valid <= 1'b0;
    else          s1_valid <= REN;
  end

  if (ECC_EN != 0) begin : g_dec
    dma_secded_dec #(.WIDTH(WIDTH), .P(P)) u_dec (
      .data      (s1_word[WIDTH-1:0]),
      .chk       (s1_word[WIDTH+P-1:WIDTH]),
      .par       (s1_word[WORD_W-1]),
      .corr_data (dec_data),
      .sb_err    (dec_sb),
      .db_err    (dec_db)
    );
  end else begin : g_nodec
    assign dec_data = s1_word[WIDTH-1:0];
    assign dec_sb   = 1'b0;
    assign dec_db   = 1'b0;
  end

  assign sb_ev = s1_valid & dec_sb;
  assign db_ev = s1_valid & dec_db;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      RDATA      <= '0;
      RVALID     <= 1'b0;
      SB_CORRECT <= 1'b0;
      DB_DETECT  <= 1'b0;
      SB_COUNT   <= '0;
      DB_COUNT   <= '0;
      ERR_ADDR   <= '0;
      ERR_VALID  <= 1'b0;
    end else begin
      RVALID     <= s1_valid;
      SB_CORRECT <= sb_ev;
      DB_DETECT  <= db_ev;
      if (s1_valid) RDATA <= dec_data;

      // A clear coinciding with an event still records that event.
      if (CLR_ERR)                           SB_COUNT <= CNT_WIDTH'(sb_ev);
      else if (sb_ev && (SB_COUNT != '1))    SB_COUNT <= SB_COUNT + 1'b1;

      if (CLR_ERR)                           DB_COUNT <= CNT_WIDTH'(db_ev);
      else if (db_ev && (DB_COUNT != '1))    DB_COUNT <= DB_COUNT + 1'b1;

      if ((sb_ev || db_ev) && (!ERR_VALID || CLR_ERR)) begin
        ERR_ADDR  <= s1_addr;
        ERR_VALID <= 1'b1;
      end else if (CLR_ERR) begin
        ERR_ADDR  <= '0;
        ERR_VALID <= 1'b0;
      end
    end
  end

endmodule
